// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a byte stream from a host link, assembles little-endian 32-bit
// words and writes them one after another into instruction memory. The core
// is held in reset until a complete, in-range image has been loaded.
// The first four bytes of each image give the word count N.
// Optional feature: define IMEM_BOOT_LOADER_CSUM_EN to require a trailing
// 32-bit checksum (mod-2^32 sum of the data words) before the core is released.
module imem_boot_loader #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic                         byte_vld_i,
  input  logic [7:0]                   byte_i,
  output logic                         byte_rdy_o,
  output logic                         wr_en_imem_o,
  output logic [31:0]                  addr_imem_o,
  output logic [31:0]                  wr_instr_imem_o,
  output logic                         core_reset_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [$clog2(IMEM_WORDS):0]  words_loaded_o
);

  localparam int unsigned WCW = $clog2(IMEM_WORDS) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
`ifdef IMEM_BOOT_LOADER_CSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       byteCnt_q;
  logic [23:0]      shift_q;
  logic [31:0]      len_q;
  logic [WCW-1:0]   wordsLoaded_q;
  logic             wrEn_q;
  logic [31:0]      wrData_q;
  logic [31:0]      addr_q;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
  logic [31:0]      csum_q;
`endif

  logic             byteAccept;
  logic             lastByte;
  logic             lastWord;
  logic             startAccept;
  logic             tooBig;
  logic [31:0]      assembled;
  logic [31:0]      wordAddr;

  // The first three bytes of a word sit in shift_q, so the full word is
  // available combinationally on the cycle its fourth byte is accepted.
  assign byteAccept  = byte_vld_i & byte_rdy_o;
  assign lastByte    = (byteCnt_q == 2'd3);
  assign assembled   = {byte_i, shift_q};
  assign lastWord    = ((32'(wordsLoaded_q) + 32'd1) == len_q);
  assign tooBig      = (assembled > 32'(IMEM_WORDS));
  assign wordAddr    = BASE_ADDR + (32'(wordsLoaded_q) << 2);
  assign startAccept = start_i &
                       ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (byteAccept && lastByte) begin
          if (tooBig) begin
            state_d = ST_ERR;
          end else if (assembled == 32'd0) begin
`ifdef IMEM_BOOT_LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (byteAccept && lastByte && lastWord) begin
`ifdef IMEM_BOOT_LOADER_CSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef IMEM_BOOT_LOADER_CSUM_EN
      ST_CSUM: begin
        if (byteAccept && lastByte) begin
          state_d = (assembled == csum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE, ST_ERR: begin
        if (start_i) state_d = ST_LEN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs; the core stays held while the final write strobe is out
  always_comb begin
    byte_rdy_o   = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    core_reset_o = 1'b1;
    case (state_q)
      ST_LEN, ST_LOAD: begin
        byte_rdy_o = 1'b1;
        busy_o     = 1'b1;
      end
`ifdef IMEM_BOOT_LOADER_CSUM_EN
      ST_CSUM: begin
        byte_rdy_o = 1'b1;
        busy_o     = 1'b1;
      end
`endif
      ST_DONE: begin
        done_o       = ~wrEn_q;
        core_reset_o = wrEn_q;
      end
      ST_ERR: begin
        err_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte assembly, length capture and the registered imem write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      byteCnt_q     <= 2'd0;
      shift_q       <= 24'd0;
      len_q         <= 32'd0;
      wordsLoaded_q <= '0;
      wrEn_q        <= 1'b0;
      wrData_q      <= 32'd0;
      addr_q        <= BASE_ADDR;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
      csum_q        <= 32'd0;
`endif
    end else begin
      wrEn_q <= 1'b0;
      if (startAccept) begin
        byteCnt_q     <= 2'd0;
        wordsLoaded_q <= '0;
        addr_q        <= BASE_ADDR;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
        csum_q        <= 32'd0;
`endif
      end else if (byteAccept) begin
        byteCnt_q <= byteCnt_q + 2'd1;
        shift_q   <= {byte_i, shift_q[23:8]};
        if ((state_q == ST_LEN) && lastByte) begin
          len_q <= assembled;
        end
        if ((state_q == ST_LOAD) && lastByte) begin
          wrEn_q        <= 1'b1;
          wrData_q      <= assembled;
          addr_q        <= wordAddr;
          wordsLoaded_q <= wordsLoaded_q + 1'b1;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
          csum_q        <= csum_q + assembled;
`endif
        end
      end
    end
  end

  assign wr_en_imem_o    = wrEn_q;
  assign addr_imem_o     = addr_q;
  assign wr_instr_imem_o = wrData_q;
  assign words_loaded_o  = wordsLoaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
// Directed bench for imem_boot_loader. Inputs change 1 time unit after the
// rising edge; outputs, handshakes and write strobes are sampled on the
// falling edge. Define IMEM_BOOT_LOADER_CSUM_EN to exercise the checksum build.
module tb_imem_boot_loader;

  localparam int IMEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        byte_vld_i;
  logic [7:0]  byte_i;
  logic        byte_rdy_o;
  logic        wr_en_imem_o;
  logic [31:0] addr_imem_o;
  logic [31:0] wr_instr_imem_o;
  logic        core_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [10:0] words_loaded_o;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  int          wrCycQ[$];
  int          hsCycQ[$];

  imem_boot_loader #(.IMEM_WORDS(IMEM_WORDS), .BASE_ADDR(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .byte_vld_i      (byte_vld_i),
    .byte_i          (byte_i),
    .byte_rdy_o      (byte_rdy_o),
    .wr_en_imem_o    (wr_en_imem_o),
    .addr_imem_o     (addr_imem_o),
    .wr_instr_imem_o (wr_instr_imem_o),
    .core_reset_o    (core_reset_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .words_loaded_o  (words_loaded_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write strobe and every byte handshake with its cycle number
  always @(negedge clk) begin
    if (wr_en_imem_o === 1'b1) begin
      wrAddrQ.push_back(addr_imem_o);
      wrDataQ.push_back(wr_instr_imem_o);
      wrCycQ.push_back(cyc);
    end
    if (byte_vld_i && byte_rdy_o) hsCycQ.push_back(cyc);
  end

  task automatic clear_log();
    wrAddrQ.delete();
    wrDataQ.delete();
    wrCycQ.delete();
    hsCycQ.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waitCnt;
    waitCnt    = 0;
    byte_vld_i = 1'b1;
    byte_i     = b;
    @(negedge clk);
    while (!byte_rdy_o && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!byte_rdy_o) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL send_byte_timeout: byte_rdy_o=%0b after %0d cycles, required 1", byte_rdy_o, waitCnt);
    end
    @(posedge clk);
    #1;
    byte_vld_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b0; start_i = 1'b0; byte_vld_i = 1'b0; byte_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    assertCount++; if (byte_rdy_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rdy: got %0b required 0", byte_rdy_o); end
    assertCount++; if (wr_en_imem_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_wren: got %0b required 0", wr_en_imem_o); end
    assertCount++; if (addr_imem_o !== 32'h0) begin failCount++; $display("[TB] FAIL reset_addr: got %h required 0", addr_imem_o); end
    assertCount++; if (wr_instr_imem_o !== 32'h0) begin failCount++; $display("[TB] FAIL reset_data: got %h required 0", wr_instr_imem_o); end
    assertCount++; if (core_reset_o !== 1'b1) begin failCount++; $display("[TB] FAIL reset_core: got %0b required 1", core_reset_o); end
    assertCount++; if (busy_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %0b required 0", busy_o); end
    assertCount++; if (done_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %0b required 0", done_o); end
    assertCount++; if (err_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err: got %0b required 0", err_o); end
    assertCount++; if (words_loaded_o !== 11'd0) begin failCount++; $display("[TB] FAIL reset_words: got %0d required 0", words_loaded_o); end
    reset = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_nominal();
    pulse_start();
    clear_log();
    send_word(32'h0000_0002);
    send_word(32'h2008_0013);
    send_word(32'h0800_0000);
    assertCount++; if (wr_en_imem_o !== 1'b1) begin failCount++; $display("[TB] FAIL nominal_last_strobe: got %0b required 1", wr_en_imem_o); end
    assertCount++; if (core_reset_o !== 1'b1) begin failCount++; $display("[TB] FAIL nominal_core_held_on_strobe: got %0b required 1", core_reset_o); end
`ifdef IMEM_BOOT_LOADER_CSUM_EN
    send_word(32'h2808_0013);
`endif
    wait_cycles(2);
    assertCount++; if (wrAddrQ.size() != 2) begin failCount++; $display("[TB] FAIL nominal_write_count: got %0d required 2", wrAddrQ.size()); end
    if (wrAddrQ.size() == 2) begin
      assertCount++; if (wrAddrQ[0] !== 32'h0) begin failCount++; $display("[TB] FAIL nominal_addr0: got %h required 00000000", wrAddrQ[0]); end
      assertCount++; if (wrDataQ[0] !== 32'h2008_0013) begin failCount++; $display("[TB] FAIL nominal_data0: got %h required 20080013", wrDataQ[0]); end
      assertCount++; if (wrAddrQ[1] !== 32'h4) begin failCount++; $display("[TB] FAIL nominal_addr1: got %h required 00000004", wrAddrQ[1]); end
      assertCount++; if (wrDataQ[1] !== 32'h0800_0000) begin failCount++; $display("[TB] FAIL nominal_data1: got %h required 08000000", wrDataQ[1]); end
      assertCount++; if (wrCycQ[0] != hsCycQ[7] + 1) begin failCount++; $display("[TB] FAIL nominal_latency0: strobe cycle %0d required %0d", wrCycQ[0], hsCycQ[7] + 1); end
      assertCount++; if (wrCycQ[1] != hsCycQ[11] + 1) begin failCount++; $display("[TB] FAIL nominal_latency1: strobe cycle %0d required %0d", wrCycQ[1], hsCycQ[11] + 1); end
    end
    assertCount++; if (words_loaded_o !== 11'd2) begin failCount++; $display("[TB] FAIL nominal_words: got %0d required 2", words_loaded_o); end
    assertCount++; if (done_o !== 1'b1) begin failCount++; $display("[TB] FAIL nominal_done: got %0b required 1", done_o); end
    assertCount++; if (core_reset_o !== 1'b0) begin failCount++; $display("[TB] FAIL nominal_core_released: got %0b required 0", core_reset_o); end
    assertCount++; if (busy_o !== 1'b0) begin failCount++; $display("[TB] FAIL nominal_busy: got %0b required 0", busy_o); end
  endtask

  task automatic test_backpressure();
    logic [7:0] img [0:11];
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20, 8'h00, 8'h00, 8'h00, 8'h08};
    pulse_start();
    clear_log();
    for (int i = 0; i < 12; i++) begin
      send_byte(img[i]);
      byte_i = 8'hFF;
      @(negedge clk);
      if (i >= 3 && i <= 10) begin
        assertCount++; if (byte_rdy_o !== 1'b1) begin failCount++; $display("[TB] FAIL bp_rdy_gap%0d: got %0b required 1", i, byte_rdy_o); end
      end
      @(posedge clk);
      #1;
    end
`ifdef IMEM_BOOT_LOADER_CSUM_EN
    send_word(32'h2808_0013);
    assertCount++; if (hsCycQ.size() != 16) begin failCount++; $display("[TB] FAIL bp_handshakes: got %0d required 16", hsCycQ.size()); end
`else
    assertCount++; if (hsCycQ.size() != 12) begin failCount++; $display("[TB] FAIL bp_handshakes: got %0d required 12", hsCycQ.size()); end
`endif
    wait_cycles(2);
    assertCount++; if (wrAddrQ.size() != 2) begin failCount++; $display("[TB] FAIL bp_write_count: got %0d required 2", wrAddrQ.size()); end
    if (wrAddrQ.size() == 2) begin
      assertCount++; if (wrAddrQ[0] !== 32'h0 || wrDataQ[0] !== 32'h2008_0013) begin failCount++; $display("[TB] FAIL bp_write0: got %h/%h required 00000000/20080013", wrAddrQ[0], wrDataQ[0]); end
      assertCount++; if (wrAddrQ[1] !== 32'h4 || wrDataQ[1] !== 32'h0800_0000) begin failCount++; $display("[TB] FAIL bp_write1: got %h/%h required 00000004/08000000", wrAddrQ[1], wrDataQ[1]); end
      assertCount++; if (wrCycQ[1] != hsCycQ[11] + 1) begin failCount++; $display("[TB] FAIL bp_latency1: strobe cycle %0d required %0d", wrCycQ[1], hsCycQ[11] + 1); end
    end
    assertCount++; if (done_o !== 1'b1) begin failCount++; $display("[TB] FAIL bp_done: got %0b required 1", done_o); end
  endtask

  task automatic test_oversize();
    pulse_start();
    clear_log();
    send_word(32'h0000_0401);
    byte_vld_i = 1'b1;
    byte_i     = 8'h55;
    wait_cycles(3);
    byte_vld_i = 1'b0;
    assertCount++; if (err_o !== 1'b1) begin failCount++; $display("[TB] FAIL over_err: got %0b required 1", err_o); end
    assertCount++; if (core_reset_o !== 1'b1) begin failCount++; $display("[TB] FAIL over_core: got %0b required 1", core_reset_o); end
    assertCount++; if (byte_rdy_o !== 1'b0) begin failCount++; $display("[TB] FAIL over_rdy: got %0b required 0", byte_rdy_o); end
    assertCount++; if (busy_o !== 1'b0) begin failCount++; $display("[TB] FAIL over_busy: got %0b required 0", busy_o); end
    assertCount++; if (wrAddrQ.size() != 0) begin failCount++; $display("[TB] FAIL over_writes: got %0d required 0", wrAddrQ.size()); end
    assertCount++; if (hsCycQ.size() != 4) begin failCount++; $display("[TB] FAIL over_handshakes: got %0d required 4", hsCycQ.size()); end
  endtask

  task automatic test_zero_reload();
    pulse_start();
    assertCount++; if (err_o !== 1'b0) begin failCount++; $display("[TB] FAIL zero_err_cleared: got %0b required 0", err_o); end
    clear_log();
    send_word(32'h0);
`ifdef IMEM_BOOT_LOADER_CSUM_EN
    send_word(32'h0);
`endif
    wait_cycles(1);
    assertCount++; if (done_o !== 1'b1) begin failCount++; $display("[TB] FAIL zero_done: got %0b required 1", done_o); end
    assertCount++; if (core_reset_o !== 1'b0) begin failCount++; $display("[TB] FAIL zero_core: got %0b required 0", core_reset_o); end
    assertCount++; if (wrAddrQ.size() != 0) begin failCount++; $display("[TB] FAIL zero_writes: got %0d required 0", wrAddrQ.size()); end
    pulse_start();
    assertCount++; if (core_reset_o !== 1'b1) begin failCount++; $display("[TB] FAIL reload_core: got %0b required 1", core_reset_o); end
    assertCount++; if (busy_o !== 1'b1) begin failCount++; $display("[TB] FAIL reload_busy: got %0b required 1", busy_o); end
    assertCount++; if (done_o !== 1'b0) begin failCount++; $display("[TB] FAIL reload_done: got %0b required 0", done_o); end
    send_word(32'h1);
    send_word(32'hDDCC_BBAA);
`ifdef IMEM_BOOT_LOADER_CSUM_EN
    send_word(32'hDDCC_BBAA);
`endif
    wait_cycles(2);
    assertCount++; if (wrAddrQ.size() != 1) begin failCount++; $display("[TB] FAIL reload_write_count: got %0d required 1", wrAddrQ.size()); end
    if (wrAddrQ.size() == 1) begin
      assertCount++; if (wrAddrQ[0] !== 32'h0 || wrDataQ[0] !== 32'hDDCC_BBAA) begin failCount++; $display("[TB] FAIL reload_write: got %h/%h required 00000000/ddccbbaa", wrAddrQ[0], wrDataQ[0]); end
    end
    assertCount++; if (words_loaded_o !== 11'd1) begin failCount++; $display("[TB] FAIL reload_words: got %0d required 1", words_loaded_o); end
    assertCount++; if (done_o !== 1'b1) begin failCount++; $display("[TB] FAIL reload_done_final: got %0b required 1", done_o); end
  endtask

`ifdef IMEM_BOOT_LOADER_CSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_word(32'h2);
    send_word(32'h2008_0013);
    send_word(32'h0800_0000);
    send_word(32'h2808_0013);
    wait_cycles(2);
    assertCount++; if (done_o !== 1'b1 || err_o !== 1'b0) begin failCount++; $display("[TB] FAIL csum_good: done/err %0b/%0b required 1/0", done_o, err_o); end
    assertCount++; if (core_reset_o !== 1'b0) begin failCount++; $display("[TB] FAIL csum_good_core: got %0b required 0", core_reset_o); end
    pulse_start();
    send_word(32'h2);
    send_word(32'h2008_0013);
    send_word(32'h0800_0000);
    send_word(32'h2808_0014);
    wait_cycles(2);
    assertCount++; if (err_o !== 1'b1 || done_o !== 1'b0) begin failCount++; $display("[TB] FAIL csum_bad: err/done %0b/%0b required 1/0", err_o, done_o); end
    assertCount++; if (core_reset_o !== 1'b1) begin failCount++; $display("[TB] FAIL csum_bad_core: got %0b required 1", core_reset_o); end
  endtask
`endif

  task automatic test_reset_midload();
    pulse_start();
    clear_log();
    send_word(32'h3);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    wait_cycles(1);
    assertCount++; if (words_loaded_o !== 11'd2) begin failCount++; $display("[TB] FAIL mid_words_before: got %0d required 2", words_loaded_o); end
    assertCount++; if (wrAddrQ.size() != 2) begin failCount++; $display("[TB] FAIL mid_writes_before: got %0d required 2", wrAddrQ.size()); end
    reset = 1'b0;
    wait_cycles(1);
    assertCount++; if (busy_o !== 1'b0 || byte_rdy_o !== 1'b0) begin failCount++; $display("[TB] FAIL mid_reset_idle: busy/rdy %0b/%0b required 0/0", busy_o, byte_rdy_o); end
    assertCount++; if (core_reset_o !== 1'b1) begin failCount++; $display("[TB] FAIL mid_reset_core: got %0b required 1", core_reset_o); end
    assertCount++; if (words_loaded_o !== 11'd0) begin failCount++; $display("[TB] FAIL mid_reset_words: got %0d required 0", words_loaded_o); end
    assertCount++; if (addr_imem_o !== 32'h0 || wr_instr_imem_o !== 32'h0) begin failCount++; $display("[TB] FAIL mid_reset_port: got %h/%h required 0/0", addr_imem_o, wr_instr_imem_o); end
    assertCount++; if (done_o !== 1'b0 || err_o !== 1'b0 || wr_en_imem_o !== 1'b0) begin failCount++; $display("[TB] FAIL mid_reset_flags: done/err/wren %0b/%0b/%0b required 0/0/0", done_o, err_o, wr_en_imem_o); end
    reset      = 1'b1;
    byte_vld_i = 1'b1;
    byte_i     = 8'h77;
    wait_cycles(3);
    byte_vld_i = 1'b0;
    assertCount++; if (byte_rdy_o !== 1'b0 || busy_o !== 1'b0) begin failCount++; $display("[TB] FAIL mid_needs_start: rdy/busy %0b/%0b required 0/0", byte_rdy_o, busy_o); end
    assertCount++; if (hsCycQ.size() != 12) begin failCount++; $display("[TB] FAIL mid_handshakes: got %0d required 12", hsCycQ.size()); end
    pulse_start();
    assertCount++; if (busy_o !== 1'b1 || byte_rdy_o !== 1'b1) begin failCount++; $display("[TB] FAIL mid_restart: busy/rdy %0b/%0b required 1/1", busy_o, byte_rdy_o); end
  endtask

  initial begin
    $display("[TB] imem_boot_loader bench starting");
    test_reset();
    test_nominal();
    test_backpressure();
    test_oversize();
    test_zero_reload();
`ifdef IMEM_BOOT_LOADER_CSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the pipelined core's instruction memory.
- Accepts a byte stream from a host link (e.g. a UART receiver) over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them sequentially into instruction memory through the imem write port.
- Holds the core in reset until a complete, in-range image has been loaded, then releases it.

Parameters:
- IMEM_WORDS, 1024, instruction memory depth in words; max loadable image size.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word aligned.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start_i  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- byte_vld_i  input  1  host byte valid
- byte_i  input  8  host byte data
- byte_rdy_o  output  1  loader ready; byte transferred when byte_vld_i & byte_rdy_o
- wr_en_imem_o  output  1  imem write strobe, one-cycle pulse per word
- addr_imem_o  output  32  imem byte address of the write
- wr_instr_imem_o  output  32  instruction word to write
- core_reset_o  output  1  active-high reset to the core; 1 = core held
- busy_o  output  1  load in progress (LEN/LOAD/CSUM)
- done_o  output  1  image loaded, core released
- err_o  output  1  load failed
- words_loaded_o  output  $clog2(IMEM_WORDS)+1  count of words written in the current load

Behaviour:
- Reset (reset==0 at a clk edge) puts the block in IDLE with:
  - byte_rdy_o=0, wr_en_imem_o=0, addr_imem_o=BASE_ADDR, wr_instr_imem_o=0
  - core_reset_o=1, busy_o=0, done_o=0, err_o=0, words_loaded_o=0
  - byte counter=0
- Reset mid-load aborts immediately; written words are not undone.
- States:
  - IDLE: byte_rdy_o=0. start_i -> LEN; clear byte counter, words_loaded_o, address and checksum.
  - LEN: byte_rdy_o=1. Four accepted bytes form N (byte 0 = bits 7:0).
    - N > IMEM_WORDS -> ERR.
    - N == 0 -> DONE (or CSUM when the feature is enabled).
    - Otherwise -> LOAD.
  - LOAD: byte_rdy_o=1.
    - On the cycle the 4th byte of a word is accepted, the assembled word is registered.
    - The next cycle drives wr_en_imem_o=1, addr_imem_o=BASE_ADDR+4*k and wr_instr_imem_o=word (write latency 1 cycle after the last byte).
    - words_loaded_o increments in the same cycle as the strobe.
    - After word N-1 is accepted -> DONE (or CSUM); its write strobe still issues in the following cycle.
  - DONE: byte_rdy_o=0, done_o=1, core_reset_o=0 from the first cycle after the final write strobe. start_i -> LEN with core_reset_o=1 and done_o=0 in the next cycle.
  - ERR: byte_rdy_o=0, err_o=1, core_reset_o=1. start_i -> LEN and clears err_o.
- start_i is ignored in LEN/LOAD/CSUM.
- Bytes presented while byte_rdy_o=0 are not consumed.
- Handshake:
  - byte_rdy_o does not depend combinationally on byte_vld_i.
  - Back-to-back bytes every cycle are supported; no bubbles are required.
  - A stalled host (byte_vld_i=0) pauses the byte counter with no timeout.
- Address arithmetic is 32-bit.
- Word index k never exceeds IMEM_WORDS-1 because of the N check. An image with N == IMEM_WORDS fills memory exactly with no wrap.
- busy_o=1 exactly in LEN, LOAD and CSUM.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CSUM_EN.
- Defined:
  - After the last data word (or immediately when N==0), the block enters CSUM and accepts 4 further bytes (little-endian) C.
  - It compares C against the mod-2^32 sum of all data words; N itself is not summed.
  - Match -> DONE. Mismatch -> ERR; core_reset_o stays 1 and data already written remains in imem.
- Not defined: CSUM state absent; LEN/LOAD exit directly to DONE as described.

Test Plan:
- Nominal load: start_i, stream 02 00 00 00, 13 00 08 20, 00 00 00 08, one byte per cycle.
  - Expect writes addr 0x0 data 0x20080013 and addr 0x4 data 0x08000000.
  - Each strobe comes 1 cycle after the word's 4th byte.
  - words_loaded_o=2, done_o=1, core_reset_o=0.
- Host backpressure: same image, byte_vld_i toggled 1/0 every cycle.
  - Expect identical writes, no duplicated or lost bytes, and byte_rdy_o held 1 throughout LOAD.
- Oversize image: N=0x401 with IMEM_WORDS=1024.
  - Expect ERR after the 4th length byte, no wr_en_imem_o pulses, core_reset_o=1, err_o=1.
- Zero length and reload: N=0 -> done_o=1 with no writes; then start_i in DONE.
  - Expect core_reset_o=1 the next cycle, busy_o=1, and a fresh 1-word load writing to addr 0x0.
- Reset mid-load: reset=0 after 2 of 3 words written.
  - Expect IDLE, all outputs at reset values, core_reset_o=1, and start_i required to restart.
- With IMEM_BOOT_LOADER_CSUM_EN: the 2-word image above plus checksum 0x28080013 -> DONE. Checksum 0x28080014 -> ERR, core_reset_o=1.
